// File: rtl/rf_regfile_param.sv
// Parametrised register file: one synchronous write port, two combinational read ports, and a sequenced bulk-clear engine.
// Optional same-cycle write-to-read forwarding is built only when RF_WRITE_BYPASS_EN is defined.
module rf_regfile_param #(
    parameter int WD       = 32,
    parameter int DEPTH    = 32,
    parameter int SEL      = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           Reg_Write_i,
    input  logic [SEL-1:0] Write_Register_i,
    input  logic [WD-1:0]  Write_Data_i,
    input  logic [SEL-1:0] Read_Register_1_i,
    input  logic [SEL-1:0] Read_Register_2_i,
    output logic [WD-1:0]  Read_Data_1_o,
    output logic [WD-1:0]  Read_Data_2_o,
    input  logic           Clear_Req_i,
    output logic           Busy_o,
    output logic           Clear_Done_o
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam logic [SEL-1:0] LAST = SEL'(DEPTH - 1);

    state_t         state, state_next;
    logic [SEL-1:0] count, count_next;
    logic           done_next;
    logic           write_ok;
    logic [WD-1:0]  regs [DEPTH];

    // Indices at or above DEPTH exist only when DEPTH is not a power of two.
    function automatic logic readable(input logic [SEL-1:0] idx);
        return (32'(idx) < DEPTH) && !(ZERO_REG && (idx == '0));
    endfunction

    assign write_ok = Reg_Write_i && (state == IDLE) && readable(Write_Register_i);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[count] <= '0;
        end else if (write_ok) begin
            regs[Write_Register_i] <= Write_Data_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= '0;
            Clear_Done_o <= 1'b0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            Clear_Done_o <= done_next;
        end
    end

    // Requests arriving while a clear is running are ignored rather than queued.
    always_comb begin
        state_next = state;
        count_next = '0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (Clear_Req_i) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                if (count == LAST) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign Busy_o = (state == CLEAR);

    always_comb begin
        Read_Data_1_o = '0;
        if (readable(Read_Register_1_i)) begin
            Read_Data_1_o = regs[Read_Register_1_i];
        end
`ifdef RF_WRITE_BYPASS_EN
        if (write_ok && (Read_Register_1_i == Write_Register_i)) begin
            Read_Data_1_o = Write_Data_i;
        end
`endif
    end

    always_comb begin
        Read_Data_2_o = '0;
        if (readable(Read_Register_2_i)) begin
            Read_Data_2_o = regs[Read_Register_2_i];
        end
`ifdef RF_WRITE_BYPASS_EN
        if (write_ok && (Read_Register_2_i == Write_Register_i)) begin
            Read_Data_2_o = Write_Data_i;
        end
`endif
    end

endmodule

// File: tb/tb_rf_regfile_param.sv
// Bench for rf_regfile_param: a 32-entry and a 20-entry instance, table-driven read/write vectors plus
// hand-written clear, held-request and mid-clear reset sequences, all compared through a scoreboard queue.
`timescale 1ns/1ps
module tb_rf_regfile_param;

`ifdef RF_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        we, clr, busy, done;
    logic [4:0]  wa, ra1, ra2;
    logic [31:0] wd, rd1, rd2;

    logic        s_we, s_clr, s_busy, s_done;
    logic [4:0]  s_wa, s_ra1, s_ra2;
    logic [31:0] s_wd, s_rd1, s_rd2;

    always #5 clk = ~clk;

    rf_regfile_param #(.WD(32), .DEPTH(32), .ZERO_REG(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .Reg_Write_i(we), .Write_Register_i(wa), .Write_Data_i(wd),
        .Read_Register_1_i(ra1), .Read_Register_2_i(ra2),
        .Read_Data_1_o(rd1), .Read_Data_2_o(rd2),
        .Clear_Req_i(clr), .Busy_o(busy), .Clear_Done_o(done)
    );

    rf_regfile_param #(.WD(32), .DEPTH(20), .ZERO_REG(1'b1)) u_dut20 (
        .clk(clk), .reset(reset),
        .Reg_Write_i(s_we), .Write_Register_i(s_wa), .Write_Data_i(s_wd),
        .Read_Register_1_i(s_ra1), .Read_Register_2_i(s_ra2),
        .Read_Data_1_o(s_rd1), .Read_Data_2_o(s_rd2),
        .Clear_Req_i(s_clr), .Busy_o(s_busy), .Clear_Done_o(s_done)
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t        vecs [9];
    string       name_q [$];
    logic [31:0] val_q [$];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] fill(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    task automatic expectPush(input string n, input logic [31:0] v);
        name_q.push_back(n);
        val_q.push_back(v);
    endtask

    task automatic checkOutput(input logic [31:0] actual);
        string       n;
        logic [31:0] v;
        checks++;
        if (val_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty actual=%h", actual);
            return;
        end
        n = name_q.pop_front();
        v = val_q.pop_front();
        if (actual !== v) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", n, actual, v);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        we  = v.we;
        wa  = v.wa;
        wd  = v.wd;
        ra1 = v.ra1;
        ra2 = v.ra2;
        expectPush($sformatf("vec%0d_port1", idx), v.e1);
        expectPush($sformatf("vec%0d_port2", idx), v.e2);
    endtask

    initial begin
        int busy_cnt, done_cnt, done_cyc, seen;
        logic busy21;

        we = 0; wa = 0; wd = 0; ra1 = 5; ra2 = 31; clr = 0;
        s_we = 0; s_wa = 0; s_wd = 0; s_ra1 = 0; s_ra2 = 0; s_clr = 0;

        vecs[0] = '{1'b0, 5'd0, 32'h0,         5'd0, 5'd31, 32'h0, 32'h0};
        vecs[1] = '{1'b1, 5'd5, 32'hDEADBEEF,  5'd5, 5'd5,  BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0};
        vecs[2] = '{1'b0, 5'd0, 32'h0,         5'd5, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 5'd0, 32'h1234,      5'd0, 5'd5,  32'h0, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 5'd0, 32'h0,         5'd0, 5'd1,  32'h0, 32'h0};
        vecs[5] = '{1'b1, 5'd7, 32'hA5A5A5A5,  5'd7, 5'd5,  BYP ? 32'hA5A5A5A5 : 32'h0, 32'hDEADBEEF};
        vecs[6] = '{1'b0, 5'd0, 32'h0,         5'd7, 5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[7] = '{1'b1, 5'd9, 32'h13579BDF,  5'd7, 5'd9,  32'hA5A5A5A5, BYP ? 32'h13579BDF : 32'h0};
        vecs[8] = '{1'b0, 5'd0, 32'h0,         5'd9, 5'd2,  32'h13579BDF, 32'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        expectPush("reset_busy", 32'h0);  checkOutput({31'b0, busy});
        expectPush("reset_done", 32'h0);  checkOutput({31'b0, done});
        expectPush("reset_rd1_r5", 32'h0); checkOutput(rd1);
        expectPush("reset_rd2_r31", 32'h0); checkOutput(rd2);
        #2 reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], i);
            @(negedge clk);
            checkOutput(rd1);
            checkOutput(rd2);
            @(posedge clk); #1;
        end
        we = 0;

        for (int i = 1; i < 32; i++) begin
            we = 1; wa = 5'(i); wd = fill(i);
            @(posedge clk); #1;
        end
        we = 0;

        // Full clear with a dropped write, an ignored re-request and a live partial read.
        clr = 1;
        @(posedge clk); #1;
        busy_cnt = 0; done_cnt = 0; done_cyc = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            we = 0; clr = (cyc == 20); ra1 = 0; ra2 = 0;
            if (cyc == 5) begin
                ra1 = 10; ra2 = 2;
                expectPush("partial_r10", fill(10));
                expectPush("partial_r2", 32'h0);
            end
            if (cyc == 10) begin
                we = 1; wa = 3; wd = 32'h55; ra1 = 3;
                expectPush("clear_write_r3_same_cycle", 32'h0);
            end
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (cyc == 5) begin checkOutput(rd1); checkOutput(rd2); end
            if (cyc == 10) checkOutput(rd1);
            @(posedge clk); #1;
        end
        we = 0; clr = 0;
        expectPush("clear_busy_cycles", 32'd32); checkOutput(32'(busy_cnt));
        expectPush("clear_done_pulses", 32'd1);  checkOutput(32'(done_cnt));
        expectPush("clear_done_cycle", 32'd32);  checkOutput(32'(done_cyc));

        for (int i = 0; i < 16; i++) begin
            ra1 = 5'(i); ra2 = 5'(i + 16);
            expectPush($sformatf("cleared_r%0d", i), 32'h0);
            expectPush($sformatf("cleared_r%0d", i + 16), 32'h0);
            @(negedge clk);
            checkOutput(rd1);
            checkOutput(rd2);
            @(posedge clk); #1;
        end

        // Reset asserted in the middle of a clear.
        we = 1; wa = 31; wd = 32'hCAFE0031;
        @(posedge clk); #1;
        we = 0; ra1 = 31;
        expectPush("r31_before_reset", 32'hCAFE0031);
        @(negedge clk); checkOutput(rd1);
        @(posedge clk); #1;
        clr = 1;
        @(posedge clk); #1;
        clr = 0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        expectPush("midreset_busy", 32'h0);   checkOutput({31'b0, busy});
        expectPush("midreset_done", 32'h0);   checkOutput({31'b0, done});
        expectPush("midreset_r31", 32'h0);    checkOutput(rd1);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        expectPush("midreset_quiet", 32'h0); checkOutput(32'(seen));
        reset = 1'b1;
        @(posedge clk); #1;
        clr = 1;
        @(posedge clk); #1;
        clr = 0;
        busy_cnt = 0; done_cnt = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            @(posedge clk); #1;
        end
        expectPush("postreset_busy_cycles", 32'd32); checkOutput(32'(busy_cnt));
        expectPush("postreset_done_pulses", 32'd1);  checkOutput(32'(done_cnt));

        // DEPTH=20 instance: out-of-range index, top index, held clear request.
        s_we = 1; s_wa = 25; s_wd = 32'hBAD00025; s_ra1 = 25;
        expectPush("d20_r25_during_write", 32'h0);
        @(negedge clk); checkOutput(s_rd1);
        @(posedge clk); #1;
        s_we = 1; s_wa = 19; s_wd = 32'h19191919; s_ra1 = 25;
        expectPush("d20_r25_after_write", 32'h0);
        @(negedge clk); checkOutput(s_rd1);
        @(posedge clk); #1;
        s_we = 0; s_ra1 = 19; s_ra2 = 25;
        expectPush("d20_r19", 32'h19191919);
        expectPush("d20_r25", 32'h0);
        @(negedge clk); checkOutput(s_rd1); checkOutput(s_rd2);
        @(posedge clk); #1;

        s_clr = 1;
        @(posedge clk); #1;
        busy_cnt = 0; done_cyc = -1; busy21 = 1'b0;
        for (int cyc = 0; cyc < 22; cyc++) begin
            s_clr = (cyc <= 20);
            @(negedge clk);
            if (cyc <= 20 && s_busy) busy_cnt++;
            if (s_done) done_cyc = cyc;
            if (cyc == 21) busy21 = s_busy;
            @(posedge clk); #1;
        end
        s_clr = 0;
        expectPush("d20_busy_cycles", 32'd20);     checkOutput(32'(busy_cnt));
        expectPush("d20_done_cycle", 32'd20);      checkOutput(32'(done_cyc));
        expectPush("d20_held_req_restart", 32'd1); checkOutput({31'b0, busy21});
        seen = 0;
        for (int k = 0; k < 30 && seen == 0; k++) begin
            @(negedge clk);
            if (s_done) seen = 1;
            @(posedge clk); #1;
        end
        expectPush("d20_second_clear_done", 32'd1); checkOutput(32'(seen));
        s_ra1 = 19;
        expectPush("d20_r19_cleared", 32'h0);
        @(negedge clk); checkOutput(s_rd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
